// File: rtl/axi_wr_router.sv
// AXI4 write-slave router: decodes a channel from awaddr and streams W beats
// into one of NUM_CH FIFOs, keeping a per-channel index counter.
module axi_wr_router #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_W-1:0]     axs_s0_awid,
  input  logic [31:0]         axs_s0_awaddr,
  input  logic [7:0]          axs_s0_awlen,
  input  logic [2:0]          axs_s0_awsize,
  input  logic [1:0]          axs_s0_awburst,
  input  logic                axs_s0_awvalid,
  output logic                axs_s0_awready,
  input  logic [DATA_W-1:0]   axs_s0_wdata,
  input  logic [DATA_W/8-1:0] axs_s0_wstrb,
  input  logic                axs_s0_wlast,
  input  logic                axs_s0_wvalid,
  output logic                axs_s0_wready,
  output logic [ID_W-1:0]     axs_s0_bid,
  output logic [1:0]          axs_s0_bresp,
  output logic                axs_s0_bvalid,
  input  logic                axs_s0_bready,
  input  logic [NUM_CH-1:0]   fifo_full,
  output logic [NUM_CH-1:0]   fifo_clr,
  output logic [NUM_CH-1:0]   fifo_push,
  output logic [DATA_W-1:0]   push_data,
  output logic [DATA_W/8-1:0] push_strb,
  output logic [IDX_W-1:0]    push_index,
  output logic                push_last
);

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_RESP = 3'd3;

  logic [2:0]       state_q, state_d;
  logic [ID_W-1:0]  awid_q;
  logic [3:0]       sel_q;
  logic             l_q;
  logic [7:0]       len_q;
  logic [2:0]       size_q;
  logic [1:0]       burst_q;
  logic [7:0]       cnt_q;
  logic             bad_q;
  logic             slverr_q;
  logic [IDX_W-1:0] idx_q [NUM_CH];

  logic [3:0]       aw_sel;
  logic             aw_bad;
  logic             aw_hs;
  logic             w_hs;
  logic             last_beat;
  logic             wlast_err;
  logic             push_en;
  logic             full_sel;
  logic [IDX_W-1:0] idx_sel;
  logic             unused_ok;

  assign aw_sel    = axs_s0_awaddr[7:4];
  assign aw_bad    = 5'(aw_sel) >= 5'(NUM_CH);
  assign aw_hs     = (state_q == ST_IDLE) && axs_s0_awvalid;
  assign w_hs      = (state_q == ST_DATA) && axs_s0_wvalid && axs_s0_wready;
  assign last_beat = (cnt_q == len_q);
  assign wlast_err = axs_s0_wlast ^ last_beat;
  assign push_en   = w_hs && !bad_q;

  // Bits of the address/burst fields that the router deliberately ignores
  assign unused_ok = ^{axs_s0_awaddr[31:8], axs_s0_awaddr[3:1], size_q, burst_q};

  // Full flag and index counter of the selected channel
  always_comb begin
    full_sel = 1'b0;
    idx_sel  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel_q == 4'(i)) begin
        full_sel = fifo_full[i];
        idx_sel  = idx_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    axs_s0_awready = 1'b0;
    axs_s0_wready  = 1'b0;
    axs_s0_bvalid  = 1'b0;
    fifo_clr       = '0;
    case (state_q)
      ST_INIT: begin
        // Clear pulse only once reset has been released
        fifo_clr = reset ? '0 : '1;
        state_d  = ST_IDLE;
      end
      ST_IDLE: begin
        axs_s0_awready = 1'b1;
        if (axs_s0_awvalid) state_d = ST_DATA;
      end
      ST_DATA: begin
        axs_s0_wready = bad_q || !full_sel;
        if (axs_s0_wvalid && (bad_q || !full_sel) && last_beat) state_d = ST_RESP;
      end
      ST_RESP: begin
        axs_s0_bvalid = 1'b1;
        if (axs_s0_bready) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Captured AW fields, beat counter and response status
  always_ff @(posedge clk) begin
    if (reset) begin
      awid_q   <= '0;
      sel_q    <= '0;
      l_q      <= 1'b0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      cnt_q    <= '0;
      bad_q    <= 1'b0;
      slverr_q <= 1'b0;
    end else if (aw_hs) begin
      awid_q   <= axs_s0_awid;
      sel_q    <= aw_sel;
      l_q      <= axs_s0_awaddr[0];
      len_q    <= axs_s0_awlen;
      size_q   <= axs_s0_awsize;
      burst_q  <= axs_s0_awburst;
      cnt_q    <= '0;
      bad_q    <= aw_bad;
      slverr_q <= aw_bad;
    end else if (w_hs) begin
      cnt_q <= cnt_q + 8'd1;
      if (wlast_err) slverr_q <= 1'b1;
    end
  end

  // Index counters advance after the final beat of an L=1 transaction
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (reset || (state_q == ST_INIT)) begin
        idx_q[i] <= '0;
      end else if (push_en && last_beat && l_q && (sel_q == 4'(i))) begin
        idx_q[i] <= idx_q[i] + IDX_W'(1);
      end
    end
  end

  always_comb begin
    fifo_push = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      fifo_push[i] = push_en && (sel_q == 4'(i));
    end
  end

  assign push_data    = push_en ? axs_s0_wdata : '0;
  assign push_strb    = push_en ? axs_s0_wstrb : '0;
  assign push_index   = push_en ? idx_sel : '0;
  assign push_last    = push_en && last_beat && l_q;
  assign axs_s0_bid   = (state_q == ST_RESP) ? awid_q : '0;
  assign axs_s0_bresp = ((state_q == ST_RESP) && slverr_q) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi_wr_router.sv
// Self-checking bench for axi_wr_router: directed vector table, hand-written
// reset/wrap sequences and randomized transactions against a channel model.
module tb_axi_wr_router;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_MASK = (1 << IDX_W) - 1;

  logic                clk;
  logic                reset;
  logic [ID_W-1:0]     awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [STRB_W-1:0]   wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [NUM_CH-1:0]   fifo_full;
  logic [NUM_CH-1:0]   fifo_clr;
  logic [NUM_CH-1:0]   fifo_push;
  logic [DATA_W-1:0]   push_data;
  logic [STRB_W-1:0]   push_strb;
  logic [IDX_W-1:0]    push_index;
  logic                push_last;

  int checks = 0;
  int errors = 0;
  int unsigned midx [NUM_CH];

  axi_wr_router #(
    .DATA_W(DATA_W), .ID_W(ID_W), .NUM_CH(NUM_CH), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset),
    .axs_s0_awid(awid), .axs_s0_awaddr(awaddr), .axs_s0_awlen(awlen),
    .axs_s0_awsize(awsize), .axs_s0_awburst(awburst),
    .axs_s0_awvalid(awvalid), .axs_s0_awready(awready),
    .axs_s0_wdata(wdata), .axs_s0_wstrb(wstrb), .axs_s0_wlast(wlast),
    .axs_s0_wvalid(wvalid), .axs_s0_wready(wready),
    .axs_s0_bid(bid), .axs_s0_bresp(bresp),
    .axs_s0_bvalid(bvalid), .axs_s0_bready(bready),
    .fifo_full(fifo_full), .fifo_clr(fifo_clr), .fifo_push(fifo_push),
    .push_data(push_data), .push_strb(push_strb),
    .push_index(push_index), .push_last(push_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  // Hold reset, check quiet outputs, release and check the clear pulse
  task automatic do_reset();
    reset = 1'b1; awvalid = 1'b0; bready = 1'b0; fifo_full = '0;
    wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = '1; wlast = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_awready", 64'(awready), 64'(0));
    chk("rst_wready", 64'(wready), 64'(0));
    chk("rst_bvalid", 64'(bvalid), 64'(0));
    chk("rst_fifo_clr", 64'(fifo_clr), 64'(0));
    chk("rst_fifo_push", 64'(fifo_push), 64'(0));
    chk("rst_push_last", 64'(push_last), 64'(0));
    chk("rst_bid", 64'(bid), 64'(0));
    chk("rst_bresp", 64'(bresp), 64'(0));
    chk("rst_push_data", 64'(push_data), 64'(0));
    chk("rst_push_strb", 64'(push_strb), 64'(0));
    chk("rst_push_index", 64'(push_index), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
    @(negedge clk);
    chk("init_fifo_clr", 64'(fifo_clr), 64'({NUM_CH{1'b1}}));
    chk("init_awready", 64'(awready), 64'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_fifo_clr", 64'(fifo_clr), 64'(0));
    chk("idle_awready", 64'(awready), 64'(1));
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) midx[c] = 0;
  endtask

  // One full write transaction; every cycle is checked against the model.
  // Entered and left #1 after a rising edge.
  task automatic run_txn(input logic [31:0] addr, input logic [7:0] len,
                         input int bad_beat, input int full_pct,
                         input int stall_beat, input int abort_after,
                         output int npush, output logic [1:0] resp);
    int sel, beat, stall_cnt;
    bit l, bad, hs, done;
    logic [ID_W-1:0] id;
    logic [1:0] exp_resp;
    logic exp_wready;
    logic [NUM_CH-1:0] exp_push;

    id  = ID_W'($urandom);
    sel = int'(addr[7:4]);
    l   = addr[0];
    bad = (sel >= int'(NUM_CH));
    exp_resp = (bad || bad_beat >= 0) ? 2'b10 : 2'b00;
    npush = 0;
    resp  = 2'b11;

    awaddr = addr; awlen = len; awid = id; awsize = 3'd2; awburst = 2'b01;
    awvalid = 1'b1;
    hs = 1'b0;
    for (int t = 0; t < 10 && !hs; t++) begin
      @(negedge clk);
      chk("aw_wready", 64'(wready), 64'(0));
      chk("aw_bvalid", 64'(bvalid), 64'(0));
      hs = awready;
      @(posedge clk);
      #1;
    end
    awvalid = 1'b0;
    awaddr  = $urandom;
    awlen   = 8'($urandom);
    if (!hs) begin
      timeout("aw_handshake");
      return;
    end

    beat = 0; stall_cnt = 0; done = 1'b0;
    for (int t = 0; t < 4000 && !done; t++) begin
      if (abort_after >= 0 && beat == abort_after) begin
        wvalid = 1'b1;
        return;
      end
      for (int c = 0; c < NUM_CH; c++)
        fifo_full[c] = ($urandom_range(0, 99) < full_pct);
      wvalid = ($urandom_range(0, 9) < 8);
      if (beat == stall_beat && stall_cnt < 5) begin
        if (!bad) fifo_full[sel] = 1'b1;
        wvalid = 1'b1;
        stall_cnt++;
      end
      wdata = $urandom;
      wstrb = STRB_W'($urandom);
      wlast = (beat == int'(len)) ^ (beat == bad_beat);
      @(negedge clk);
      exp_wready = bad ? 1'b1 : !fifo_full[sel];
      exp_push = '0;
      if (!bad && wvalid && exp_wready) exp_push[sel] = 1'b1;
      chk("w_wready", 64'(wready), 64'(exp_wready));
      chk("w_fifo_push", 64'(fifo_push), 64'(exp_push));
      chk("w_awready", 64'(awready), 64'(0));
      chk("w_bvalid", 64'(bvalid), 64'(0));
      if (exp_push != '0) begin
        chk("push_data", 64'(push_data), 64'(wdata));
        chk("push_strb", 64'(push_strb), 64'(wstrb));
        chk("push_index", 64'(push_index), 64'(midx[sel]));
        chk("push_last", 64'(push_last), 64'((beat == int'(len)) && l));
      end else begin
        chk("push_last_idle", 64'(push_last), 64'(0));
      end
      if (fifo_push != '0) npush++;
      hs = wvalid && wready;
      @(posedge clk);
      #1;
      if (hs) begin
        if (beat == int'(len)) done = 1'b1;
        beat++;
      end
    end
    wvalid = 1'b0; wlast = 1'b0; fifo_full = '0;
    if (!done) begin
      timeout("w_beats");
      return;
    end
    if (l && !bad) midx[sel] = (midx[sel] + 1) & IDX_MASK;

    hs = 1'b0;
    for (int t = 0; t < 50 && !hs; t++) begin
      bready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      chk("b_bvalid", 64'(bvalid), 64'(1));
      chk("b_wready", 64'(wready), 64'(0));
      chk("b_awready", 64'(awready), 64'(0));
      chk("b_push", 64'(fifo_push), 64'(0));
      if (bvalid) begin
        chk("b_bid", 64'(bid), 64'(id));
        chk("b_bresp", 64'(bresp), 64'(exp_resp));
        resp = bresp;
      end
      hs = bvalid && bready;
      @(posedge clk);
      #1;
    end
    bready = 1'b0;
    if (!hs) timeout("b_handshake");
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int          bad_beat;
    int          full_pct;
    int          stall_beat;
    logic [1:0]  exp_resp;
    int          exp_push;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  initial begin
    int npush;
    logic [1:0] resp;
    logic [31:0] addr;
    logic [7:0] len;
    int bad_beat;

    reset = 1'b1; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; fifo_full = '0;

    vecs[0] = '{32'h21, 8'd0, -1,  0, -1, 2'b00, 1};
    vecs[1] = '{32'h21, 8'd0, -1,  0, -1, 2'b00, 1};
    vecs[2] = '{32'h10, 8'd3, -1,  0, -1, 2'b00, 4};
    vecs[3] = '{32'h00, 8'd3, -1,  0,  1, 2'b00, 4};
    vecs[4] = '{32'h50, 8'd1, -1,  0, -1, 2'b10, 0};
    vecs[5] = '{32'h31, 8'd1,  0,  0, -1, 2'b10, 2};
    vecs[6] = '{32'h20, 8'd2,  2, 30, -1, 2'b10, 3};
    vecs[7] = '{32'h01, 8'd7, -1, 40, -1, 2'b00, 8};
    vecs[8] = '{32'hF1, 8'd0, -1,  0, -1, 2'b10, 0};

    do_reset();

    for (int i = 0; i < NV; i++) begin
      run_txn(vecs[i].addr, vecs[i].len, vecs[i].bad_beat, vecs[i].full_pct,
              vecs[i].stall_beat, -1, npush, resp);
      chk($sformatf("vec%0d_bresp", i), 64'(resp), 64'(vecs[i].exp_resp));
      chk($sformatf("vec%0d_npush", i), 64'(npush), 64'(vecs[i].exp_push));
    end

    for (int i = 0; i < 200; i++) begin
      addr = {24'($urandom), 4'($urandom_range(0, 5)), 3'($urandom), 1'($urandom)};
      len  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 4));
      bad_beat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      run_txn(addr, len, bad_beat, int'($urandom_range(0, 50)), -1, -1, npush, resp);
    end

    // Reset in the middle of a burst abandons it
    run_txn(32'h11, 8'd3, -1, 0, -1, 2, npush, resp);
    chk("abort_npush", 64'(npush), 64'(2));
    do_reset();
    wvalid = 1'b1; wlast = 1'b1; wdata = $urandom;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("abort_push", 64'(fifo_push), 64'(0));
      chk("abort_wready", 64'(wready), 64'(0));
      chk("abort_bvalid", 64'(bvalid), 64'(0));
      @(posedge clk);
      #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    run_txn(32'h11, 8'd0, -1, 0, -1, -1, npush, resp);
    chk("post_abort_npush", 64'(npush), 64'(1));

    // Index counter wrap on channel 3, then a wlast mismatch
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      run_txn(32'h31, 8'd0, -1, 0, -1, -1, npush, resp);
    end
    chk("wrap_model_idx", 64'(midx[3]), 64'(0));
    run_txn(32'h31, 8'd1, 0, 0, -1, -1, npush, resp);
    chk("mismatch_bresp", 64'(resp), 64'(2'b10));
    chk("mismatch_npush", 64'(npush), 64'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
